multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning max cycles a memory access may wait for mem_ready before bus-error trap (1..255).
REQ-002 SHALL have parameter EN_REGIMM, default 1, meaning opcode 6'h01 (BLTZ/BGEZ) decoded when 1, treated as invalid when 0.
REQ-003 SHALL have ports, one per line (clock and reset first):
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opc  in  6  opcode field of the instruction register
- func  in  6  function field of the instruction register
- rt_field  in  5  rt field (REGIMM subcode)
- mem_ready  in  1  memory completes current access this cycle
- state  out  3  current FSM state
- memRead  out  1  memory read request (fetch or load)
- memWrite  out  1  memory write request (store)
- instrFetch  out  1  current access is an instruction fetch
- irWrite  out  1  one-cycle instruction register load
- pcIncr  out  1  one-cycle PC+4 update
- isJmp  out  1  one-cycle jump PC update
- branch  out  3  branch condition code (1 BEQ, 2 BNE, 5 BGEZ, 6 BLTZ), valid in EXEC only
- rfWriteEnable  out  1  one-cycle register write strobe
- rfWriteAddrSel  out  1  1 = rd, 0 = rt
- rfWriteDataSel  out  2  00 ALU, 01 memory
- aluSrc  out  2  0 reg, 1 imm, 2 shamt, 3 reg shift amount
- aluOp1_source  out  1  1 = rt as shift operand
- aluFunc  out  4  ALU code per alu_defines.vh
- bitXtend  out  1  0 sign-, 1 zero-extend immediate
- isLui  out  1  LUI operation
- memDataSize  out  2  00 word, 01 half, 10 byte
- memBitExt  out  1  1 = zero-extend load data
- invOpcode  out  1  sticky: invalid instruction trapped
- busError  out  1  sticky: memory timeout trapped
- instrDone  out  1  one-cycle pulse on instruction retirement

Function
REQ-004 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
REQ-005 FETCH: memRead=1, instrFetch=1; on mem_ready: irWrite=1, pcIncr=1 same cycle, next DECODE; else stay.
REQ-006 DECODE: decode opc/func/rt_field with the same instruction set and control encodings as the existing single-cycle decoder (R-type ALU/shift, ADDI..LUI, LW/LB/LBU/LH/LHU, SW/SB/SH, BEQ/BNE, REGIMM, J); decoded controls registered and held stable through EXEC/MEM/WB.
REQ-007 DECODE, J: isJmp=1 for that cycle, instrDone=1, next FETCH.
REQ-008 DECODE, invalid opc, func, or REGIMM subcode (not 0/1, or EN_REGIMM=0): next TRAP, invOpcode set.
REQ-009 DECODE, all other valid instructions: next EXEC.
REQ-010 EXEC: ALU/shift/LUI -> WB; load/store -> MEM; branch: branch output driven for that cycle, instrDone=1, next FETCH.
REQ-011 MEM: memRead (load) or memWrite (store) held until mem_ready; store completes -> instrDone=1, FETCH; load completes -> WB.
REQ-012 WB: rfWriteEnable=1 exactly one cycle, instrDone=1, next FETCH.
REQ-013 Timeout counter: cleared on entering FETCH or MEM, increments each waiting cycle; counter reaching MEM_TIMEOUT without mem_ready -> TRAP, busError set. mem_ready on the terminal cycle wins (access completes, no trap).
REQ-014 TRAP: all request/strobe outputs 0; state held until rst; invOpcode/busError remain set.
REQ-015 Outside its state, every strobe (irWrite, pcIncr, isJmp, rfWriteEnable, instrDone, memWrite) SHALL be 0; branch SHALL be 0 outside EXEC.
REQ-016 mem_ready in DECODE, EXEC, WB or TRAP SHALL be ignored.

Reset
REQ-017 rst high at a rising edge: state=FETCH; all outputs 0 except memRead=1, instrFetch=1 (FETCH outputs); invOpcode, busError, timeout counter cleared; mid-access reset abandons the access.
REQ-018 rst SHALL take priority over every transition, including TRAP exit.

Verification
REQ-019 ADD (opc 0, func 0x20), mem_ready on 1st fetch cycle -> FETCH,DECODE,EXEC,WB; rfWriteEnable=1, rfWriteAddrSel=1 in cycle 4; instrDone once.
REQ-020 LW with mem_ready delayed 3 cycles in MEM -> memRead held 3+1 cycles, WB with rfWriteDataSel=01, memDataSize=00.
REQ-021 SB -> MEM memWrite=1, memDataSize=10; on mem_ready instrDone=1, next FETCH, no rfWriteEnable.
REQ-022 Fetch with mem_ready never asserted, MEM_TIMEOUT=15 -> TRAP after 15 wait cycles, busError=1; mem_ready on cycle 15 instead -> no trap.
REQ-023 opc 6'h3F -> TRAP, invOpcode=1; opc 6'h01, rt=1 with EN_REGIMM=0 -> TRAP; rst then returns to FETCH with flags clear.
REQ-024 BNE -> branch=2 only in EXEC; J -> isJmp pulse in DECODE, 2-cycle instruction.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing with
// registered decode, memory-wait timeout and sticky trap flags.
`timescale 1ns/1ps
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int EN_REGIMM   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic [4:0] rt_field,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       memRead,
  output logic       memWrite,
  output logic       instrFetch,
  output logic       irWrite,
  output logic       pcIncr,
  output logic       isJmp,
  output logic [2:0] branch,
  output logic       rfWriteEnable,
  output logic       rfWriteAddrSel,
  output logic [1:0] rfWriteDataSel,
  output logic [1:0] aluSrc,
  output logic       aluOp1_source,
  output logic [3:0] aluFunc,
  output logic       bitXtend,
  output logic       isLui,
  output logic [1:0] memDataSize,
  output logic       memBitExt,
  output logic       invOpcode,
  output logic       busError,
  output logic       instrDone
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_INVALID = 3'd0, CLS_ALU = 3'd1, CLS_LOAD = 3'd2,
    CLS_STORE = 3'd3, CLS_BRANCH = 3'd4, CLS_JUMP = 3'd5
  } instrClass_t;

  typedef struct packed {
    instrClass_t cls;
    logic [2:0]  branch;
    logic        rfWriteAddrSel;
    logic [1:0]  rfWriteDataSel;
    logic [1:0]  aluSrc;
    logic        aluOp1Source;
    logic [3:0]  aluFunc;
    logic        bitXtend;
    logic        isLui;
    logic [1:0]  memDataSize;
    logic        memBitExt;
  } ctrl_t;

  // ALU function codes shared with the datapath ALU
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     curState, nextState;
  ctrl_t      dec, ctrlReg;
  logic [7:0] waitCnt;
  logic       waitLast;

  assign waitLast = (waitCnt == WAIT_LAST);

  // Combinational instruction decoder, only latched while in DECODE.
  always_comb begin : decodeLogic
    // NOTE: every field gets a default first so no latch is inferred.
    dec = '0;
    case (opc)
      6'h00: begin
        dec.cls = CLS_ALU;
        dec.rfWriteAddrSel = 1'b1;
        case (func)
          6'h20, 6'h21: dec.aluFunc = ALU_ADD;
          6'h22, 6'h23: dec.aluFunc = ALU_SUB;
          6'h24: dec.aluFunc = ALU_AND;
          6'h25: dec.aluFunc = ALU_OR;
          6'h26: dec.aluFunc = ALU_XOR;
          6'h27: dec.aluFunc = ALU_NOR;
          6'h2A: dec.aluFunc = ALU_SLT;
          6'h2B: dec.aluFunc = ALU_SLTU;
          6'h00: begin dec.aluFunc = ALU_SLL; dec.aluSrc = 2'd2; dec.aluOp1Source = 1'b1; end
          6'h02: begin dec.aluFunc = ALU_SRL; dec.aluSrc = 2'd2; dec.aluOp1Source = 1'b1; end
          6'h03: begin dec.aluFunc = ALU_SRA; dec.aluSrc = 2'd2; dec.aluOp1Source = 1'b1; end
          6'h04: begin dec.aluFunc = ALU_SLL; dec.aluSrc = 2'd3; dec.aluOp1Source = 1'b1; end
          6'h06: begin dec.aluFunc = ALU_SRL; dec.aluSrc = 2'd3; dec.aluOp1Source = 1'b1; end
          6'h07: begin dec.aluFunc = ALU_SRA; dec.aluSrc = 2'd3; dec.aluOp1Source = 1'b1; end
          default: dec.cls = CLS_INVALID;
        endcase
      end
      6'h08, 6'h09: begin dec.cls = CLS_ALU; dec.aluSrc = 2'd1; dec.aluFunc = ALU_ADD; end
      6'h0A: begin dec.cls = CLS_ALU; dec.aluSrc = 2'd1; dec.aluFunc = ALU_SLT; end
      6'h0B: begin dec.cls = CLS_ALU; dec.aluSrc = 2'd1; dec.aluFunc = ALU_SLTU; end
      6'h0C: begin dec.cls = CLS_ALU; dec.aluSrc = 2'd1; dec.aluFunc = ALU_AND; dec.bitXtend = 1'b1; end
      6'h0D: begin dec.cls = CLS_ALU; dec.aluSrc = 2'd1; dec.aluFunc = ALU_OR;  dec.bitXtend = 1'b1; end
      6'h0E: begin dec.cls = CLS_ALU; dec.aluSrc = 2'd1; dec.aluFunc = ALU_XOR; dec.bitXtend = 1'b1; end
      6'h0F: begin dec.cls = CLS_ALU; dec.aluSrc = 2'd1; dec.aluFunc = ALU_ADD; dec.isLui = 1'b1; end
      // opc[1:0] selects width (00 byte, 01 half, 11 word); opc[2] marks unsigned loads
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.cls = CLS_LOAD;
        dec.aluSrc = 2'd1;
        dec.rfWriteDataSel = 2'b01;
        dec.memDataSize = (opc[1:0] == 2'b11) ? 2'b00 : (opc[0] ? 2'b01 : 2'b10);
        dec.memBitExt = opc[2];
      end
      6'h28, 6'h29, 6'h2B: begin
        dec.cls = CLS_STORE;
        dec.aluSrc = 2'd1;
        dec.memDataSize = (opc[1:0] == 2'b11) ? 2'b00 : (opc[0] ? 2'b01 : 2'b10);
      end
      6'h04: begin dec.cls = CLS_BRANCH; dec.branch = 3'd1; dec.aluFunc = ALU_SUB; end
      6'h05: begin dec.cls = CLS_BRANCH; dec.branch = 3'd2; dec.aluFunc = ALU_SUB; end
      6'h01: begin
        if (EN_REGIMM != 0 && rt_field == 5'd0) begin
          dec.cls = CLS_BRANCH; dec.branch = 3'd6; dec.aluFunc = ALU_SUB;
        end else if (EN_REGIMM != 0 && rt_field == 5'd1) begin
          dec.cls = CLS_BRANCH; dec.branch = 3'd5; dec.aluFunc = ALU_SUB;
        end
      end
      6'h02: dec.cls = CLS_JUMP;
      default: dec.cls = CLS_INVALID;
    endcase
  end

  always_ff @(posedge clk) begin : stateReg
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) curState <= FETCH;
    else     curState <= nextState;
  end

  always_comb begin : nextStateLogic
    nextState = curState;
    case (curState)
      FETCH: begin
        if (mem_ready)     nextState = DECODE;
        else if (waitLast) nextState = TRAP;
      end
      DECODE: begin
        case (dec.cls)
          CLS_JUMP:    nextState = FETCH;
          CLS_INVALID: nextState = TRAP;
          default:     nextState = EXEC;
        endcase
      end
      EXEC: begin
        case (ctrlReg.cls)
          CLS_ALU:              nextState = WB;
          CLS_LOAD, CLS_STORE:  nextState = MEM;
          default:              nextState = FETCH;
        endcase
      end
      MEM: begin
        if (mem_ready)     nextState = (ctrlReg.cls == CLS_LOAD) ? WB : FETCH;
        else if (waitLast) nextState = TRAP;
      end
      WB:      nextState = FETCH;
      TRAP:    nextState = TRAP;
      default: nextState = FETCH;
    endcase
  end

  // Decoded controls, wait counter and sticky trap flags.
  always_ff @(posedge clk) begin : dataRegs
    if (rst) begin
      ctrlReg   <= '0;
      waitCnt   <= '0;
      invOpcode <= 1'b0;
      busError  <= 1'b0;
    end else begin
      if (curState == DECODE) ctrlReg <= dec;
      if (nextState != curState)                      waitCnt <= '0;
      else if (curState == FETCH || curState == MEM) waitCnt <= waitCnt + 8'd1;
      if (curState == DECODE && dec.cls == CLS_INVALID) invOpcode <= 1'b1;
      if ((curState == FETCH || curState == MEM) && !mem_ready && waitLast) busError <= 1'b1;
    end
  end

  always_comb begin : outputLogic
    memRead       = 1'b0;
    memWrite      = 1'b0;
    instrFetch    = 1'b0;
    irWrite       = 1'b0;
    pcIncr        = 1'b0;
    isJmp         = 1'b0;
    branch        = 3'd0;
    rfWriteEnable = 1'b0;
    instrDone     = 1'b0;
    case (curState)
      FETCH: begin
        memRead    = 1'b1;
        instrFetch = 1'b1;
        irWrite    = mem_ready;
        pcIncr     = mem_ready;
      end
      DECODE: begin
        isJmp     = (dec.cls == CLS_JUMP);
        instrDone = (dec.cls == CLS_JUMP);
      end
      EXEC: begin
        if (ctrlReg.cls == CLS_BRANCH) begin
          branch    = ctrlReg.branch;
          instrDone = 1'b1;
        end
      end
      MEM: begin
        memRead   = (ctrlReg.cls == CLS_LOAD);
        memWrite  = (ctrlReg.cls == CLS_STORE);
        instrDone = (ctrlReg.cls == CLS_STORE) && mem_ready;
      end
      WB: begin
        rfWriteEnable = 1'b1;
        instrDone     = 1'b1;
      end
      default: ;
    endcase
  end

  assign state          = curState;
  assign rfWriteAddrSel = ctrlReg.rfWriteAddrSel;
  assign rfWriteDataSel = ctrlReg.rfWriteDataSel;
  assign aluSrc         = ctrlReg.aluSrc;
  assign aluOp1_source  = ctrlReg.aluOp1Source;
  assign aluFunc        = ctrlReg.aluFunc;
  assign bitXtend       = ctrlReg.bitXtend;
  assign isLui          = ctrlReg.isLui;
  assign memDataSize    = ctrlReg.memDataSize;
  assign memBitExt      = ctrlReg.memBitExt;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each scenario queues per-cycle stimulus with the expected
// outputs, then replays the queue and compares at the falling edge.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [2:0] st;
    logic       memRead, memWrite, instrFetch, irWrite, pcIncr, isJmp;
    logic [2:0] branch;
    logic       rfWriteEnable, invOpcode, busError, instrDone;
  } strobe_t;

  typedef struct packed {
    logic       rfWriteAddrSel;
    logic [1:0] rfWriteDataSel;
    logic [1:0] aluSrc;
    logic       aluOp1;
    logic [3:0] aluFunc;
    logic       bitXtend, isLui;
    logic [1:0] memDataSize;
    logic       memBitExt;
  } ctrl_t;

  typedef struct {
    logic rdy, rstIn, chk, chk2;
    strobe_t s;
    ctrl_t c;
    logic [2:0] st2;
    logic inv2;
  } exp_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam ctrl_t C_ZERO = '0;
  localparam ctrl_t C_ADD  = '{1'b1, 2'd0, 2'd0, 1'b0, ALU_ADD, 1'b0, 1'b0, 2'd0, 1'b0};
  localparam ctrl_t C_LW   = '{1'b0, 2'd1, 2'd1, 1'b0, ALU_ADD, 1'b0, 1'b0, 2'd0, 1'b0};
  localparam ctrl_t C_SB   = '{1'b0, 2'd0, 2'd1, 1'b0, ALU_ADD, 1'b0, 1'b0, 2'd2, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opc = '0, func = '0;
  logic [4:0] rt_field = '0;
  logic mem_ready = 1'b0;

  logic [2:0] state, branch, stateB, branchB;
  logic memRead, memWrite, instrFetch, irWrite, pcIncr, isJmp, rfWriteEnable, rfWriteAddrSel;
  logic aluOp1_source, bitXtend, isLui, memBitExt, invOpcode, busError, instrDone;
  logic [1:0] rfWriteDataSel, aluSrc, memDataSize;
  logic [3:0] aluFunc;
  logic memReadB, memWriteB, instrFetchB, irWriteB, pcIncrB, isJmpB, rfWriteEnableB, rfWriteAddrSelB;
  logic aluOp1_sourceB, bitXtendB, isLuiB, memBitExtB, invOpcodeB, busErrorB, instrDoneB;
  logic [1:0] rfWriteDataSelB, aluSrcB, memDataSizeB;
  logic [3:0] aluFuncB;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic invF = 1'b0, busF = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_TIMEOUT(15), .EN_REGIMM(1)) dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .rt_field(rt_field), .mem_ready(mem_ready),
    .state(state), .memRead(memRead), .memWrite(memWrite), .instrFetch(instrFetch),
    .irWrite(irWrite), .pcIncr(pcIncr), .isJmp(isJmp), .branch(branch),
    .rfWriteEnable(rfWriteEnable), .rfWriteAddrSel(rfWriteAddrSel), .rfWriteDataSel(rfWriteDataSel),
    .aluSrc(aluSrc), .aluOp1_source(aluOp1_source), .aluFunc(aluFunc), .bitXtend(bitXtend),
    .isLui(isLui), .memDataSize(memDataSize), .memBitExt(memBitExt), .invOpcode(invOpcode),
    .busError(busError), .instrDone(instrDone)
  );

  multicycle_control_unit #(.MEM_TIMEOUT(15), .EN_REGIMM(0)) dutNoRegimm (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .rt_field(rt_field), .mem_ready(mem_ready),
    .state(stateB), .memRead(memReadB), .memWrite(memWriteB), .instrFetch(instrFetchB),
    .irWrite(irWriteB), .pcIncr(pcIncrB), .isJmp(isJmpB), .branch(branchB),
    .rfWriteEnable(rfWriteEnableB), .rfWriteAddrSel(rfWriteAddrSelB), .rfWriteDataSel(rfWriteDataSelB),
    .aluSrc(aluSrcB), .aluOp1_source(aluOp1_sourceB), .aluFunc(aluFuncB), .bitXtend(bitXtendB),
    .isLui(isLuiB), .memDataSize(memDataSizeB), .memBitExt(memBitExtB), .invOpcode(invOpcodeB),
    .busError(busErrorB), .instrDone(instrDoneB)
  );

  function automatic strobe_t obsS();
    obsS = '{state, memRead, memWrite, instrFetch, irWrite, pcIncr, isJmp, branch,
             rfWriteEnable, invOpcode, busError, instrDone};
  endfunction

  function automatic ctrl_t obsC();
    obsC = '{rfWriteAddrSel, rfWriteDataSel, aluSrc, aluOp1_source, aluFunc, bitXtend,
             isLui, memDataSize, memBitExt};
  endfunction

  // Expected per-state outputs
  function automatic strobe_t baseS(input logic [2:0] st);
    baseS = '0;
    baseS.st = st;
    baseS.invOpcode = invF;
    baseS.busError = busF;
  endfunction

  function automatic strobe_t fetchS(input logic rdy);
    fetchS = baseS(3'd0);
    fetchS.memRead = 1'b1;
    fetchS.instrFetch = 1'b1;
    fetchS.irWrite = rdy;
    fetchS.pcIncr = rdy;
  endfunction

  function automatic strobe_t decodeS(input logic jmp);
    decodeS = baseS(3'd1);
    decodeS.isJmp = jmp;
    decodeS.instrDone = jmp;
  endfunction

  function automatic strobe_t execS(input logic [2:0] br);
    execS = baseS(3'd2);
    execS.branch = br;
    execS.instrDone = (br != 3'd0);
  endfunction

  function automatic strobe_t memS(input logic load, input logic rdy);
    memS = baseS(3'd3);
    memS.memRead = load;
    memS.memWrite = !load;
    memS.instrDone = !load && rdy;
  endfunction

  function automatic strobe_t wbS();
    wbS = baseS(3'd4);
    wbS.rfWriteEnable = 1'b1;
    wbS.instrDone = 1'b1;
  endfunction

  function automatic strobe_t trapS();
    trapS = baseS(3'd7);
  endfunction

  task automatic push(input logic rdy, input logic r, input strobe_t s, input logic chk, input ctrl_t c);
    exp_t e;
    e.rdy = rdy; e.rstIn = r; e.s = s; e.chk = chk; e.c = c;
    e.chk2 = 1'b0; e.st2 = 3'd0; e.inv2 = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push2(input logic rdy, input logic r, input strobe_t s, input logic [2:0] st2, input logic inv2);
    exp_t e;
    e.rdy = rdy; e.rstIn = r; e.s = s; e.chk = 1'b0; e.c = '0;
    e.chk2 = 1'b1; e.st2 = st2; e.inv2 = inv2;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    invF = 1'b0; busF = 1'b0;
    push(1'b0, 1'b1, fetchS(1'b0), 1'b1, C_ZERO);
    push(1'b0, 1'b0, fetchS(1'b0), 1'b1, C_ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; rst = e.rstIn;
      @(negedge clk);
      checks++;
      if (obsS() !== e.s) begin failures++; $display("FAIL reset strobes t=%0t got=%h exp=%h", $time, obsS(), e.s); end
      if (e.chk) begin
        checks++;
        if (obsC() !== e.c) begin failures++; $display("FAIL reset ctrl t=%0t got=%h exp=%h", $time, obsC(), e.c); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    exp_t e;
    opc = 6'h00; func = 6'h20; rt_field = 5'd0;
    push(1'b1, 1'b0, fetchS(1'b1), 1'b0, C_ZERO);
    push(1'b1, 1'b0, decodeS(1'b0), 1'b0, C_ZERO);
    push(1'b1, 1'b0, execS(3'd0), 1'b1, C_ADD);
    push(1'b1, 1'b0, wbS(), 1'b1, C_ADD);
    push(1'b0, 1'b0, fetchS(1'b0), 1'b0, C_ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; rst = e.rstIn;
      @(negedge clk);
      checks++;
      if (obsS() !== e.s) begin failures++; $display("FAIL add strobes t=%0t got=%h exp=%h", $time, obsS(), e.s); end
      if (e.chk) begin
        checks++;
        if (obsC() !== e.c) begin failures++; $display("FAIL add ctrl t=%0t got=%h exp=%h", $time, obsC(), e.c); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_word();
    exp_t e;
    opc = 6'h23;
    push(1'b0, 1'b0, fetchS(1'b0), 1'b0, C_ZERO);
    push(1'b1, 1'b0, fetchS(1'b1), 1'b0, C_ZERO);
    push(1'b0, 1'b0, decodeS(1'b0), 1'b0, C_ZERO);
    push(1'b0, 1'b0, execS(3'd0), 1'b1, C_LW);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, memS(1'b1, 1'b0), 1'b1, C_LW);
    push(1'b1, 1'b0, memS(1'b1, 1'b1), 1'b1, C_LW);
    push(1'b0, 1'b0, wbS(), 1'b1, C_LW);
    push(1'b0, 1'b0, fetchS(1'b0), 1'b0, C_ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; rst = e.rstIn;
      @(negedge clk);
      checks++;
      if (obsS() !== e.s) begin failures++; $display("FAIL lw strobes t=%0t got=%h exp=%h", $time, obsS(), e.s); end
      if (e.chk) begin
        checks++;
        if (obsC() !== e.c) begin failures++; $display("FAIL lw ctrl t=%0t got=%h exp=%h", $time, obsC(), e.c); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_byte();
    exp_t e;
    opc = 6'h28;
    push(1'b1, 1'b0, fetchS(1'b1), 1'b0, C_ZERO);
    push(1'b0, 1'b0, decodeS(1'b0), 1'b0, C_ZERO);
    push(1'b0, 1'b0, execS(3'd0), 1'b1, C_SB);
    push(1'b0, 1'b0, memS(1'b0, 1'b0), 1'b1, C_SB);
    push(1'b1, 1'b0, memS(1'b0, 1'b1), 1'b1, C_SB);
    push(1'b0, 1'b0, fetchS(1'b0), 1'b0, C_ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; rst = e.rstIn;
      @(negedge clk);
      checks++;
      if (obsS() !== e.s) begin failures++; $display("FAIL sb strobes t=%0t got=%h exp=%h", $time, obsS(), e.s); end
      if (e.chk) begin
        checks++;
        if (obsC() !== e.c) begin failures++; $display("FAIL sb ctrl t=%0t got=%h exp=%h", $time, obsC(), e.c); end
      end
      @(posedge clk); #1;
    end
  endtask

  // BNE, then BGEZ and BLTZ, each sampled through its EXEC cycle and into the next fetch
  task automatic test_branch();
    exp_t e;
    logic [5:0] opcs [3];
    logic [4:0] rts [3];
    logic [2:0] codes [3];
    opcs = '{6'h05, 6'h01, 6'h01};
    rts = '{5'd0, 5'd1, 5'd0};
    codes = '{3'd2, 3'd5, 3'd6};
    for (int k = 0; k < 3; k++) begin
      opc = opcs[k]; rt_field = rts[k];
      push(1'b1, 1'b0, fetchS(1'b1), 1'b0, C_ZERO);
      push(1'b0, 1'b0, decodeS(1'b0), 1'b0, C_ZERO);
      push(1'b1, 1'b0, execS(codes[k]), 1'b0, C_ZERO);
      push(1'b0, 1'b0, fetchS(1'b0), 1'b0, C_ZERO);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        mem_ready = e.rdy; rst = e.rstIn;
        @(negedge clk);
        checks++;
        if (obsS() !== e.s) begin failures++; $display("FAIL branch%0d strobes t=%0t got=%h exp=%h", k, $time, obsS(), e.s); end
        @(posedge clk); #1;
      end
    end
    rt_field = 5'd0;
  endtask

  task automatic test_jump();
    exp_t e;
    opc = 6'h02;
    push(1'b1, 1'b0, fetchS(1'b1), 1'b0, C_ZERO);
    push(1'b0, 1'b0, decodeS(1'b1), 1'b0, C_ZERO);
    push(1'b0, 1'b0, fetchS(1'b0), 1'b0, C_ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; rst = e.rstIn;
      @(negedge clk);
      checks++;
      if (obsS() !== e.s) begin failures++; $display("FAIL jump strobes t=%0t got=%h exp=%h", $time, obsS(), e.s); end
      @(posedge clk); #1;
    end
  endtask

  // Ready on the 15th fetch wait cycle completes; 15 cycles without ready traps
  task automatic test_fetch_timeout();
    exp_t e;
    opc = 6'h02;
    push(1'b0, 1'b1, fetchS(1'b0), 1'b0, C_ZERO);
    for (int i = 0; i < 14; i++) push(1'b0, 1'b0, fetchS(1'b0), 1'b0, C_ZERO);
    push(1'b1, 1'b0, fetchS(1'b1), 1'b0, C_ZERO);
    push(1'b0, 1'b0, decodeS(1'b1), 1'b0, C_ZERO);
    for (int i = 0; i < 15; i++) push(1'b0, 1'b0, fetchS(1'b0), 1'b0, C_ZERO);
    busF = 1'b1;
    push(1'b1, 1'b0, trapS(), 1'b0, C_ZERO);
    push(1'b1, 1'b0, trapS(), 1'b0, C_ZERO);
    push(1'b0, 1'b1, trapS(), 1'b0, C_ZERO);
    busF = 1'b0;
    push(1'b0, 1'b0, fetchS(1'b0), 1'b0, C_ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; rst = e.rstIn;
      @(negedge clk);
      checks++;
      if (obsS() !== e.s) begin failures++; $display("FAIL fetch_timeout strobes t=%0t got=%h exp=%h", $time, obsS(), e.s); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_timeout();
    exp_t e;
    opc = 6'h2B;
    push(1'b0, 1'b1, fetchS(1'b0), 1'b0, C_ZERO);
    push(1'b1, 1'b0, fetchS(1'b1), 1'b0, C_ZERO);
    push(1'b0, 1'b0, decodeS(1'b0), 1'b0, C_ZERO);
    push(1'b0, 1'b0, execS(3'd0), 1'b0, C_ZERO);
    for (int i = 0; i < 15; i++) push(1'b0, 1'b0, memS(1'b0, 1'b0), 1'b0, C_ZERO);
    busF = 1'b1;
    push(1'b1, 1'b0, trapS(), 1'b0, C_ZERO);
    push(1'b0, 1'b1, trapS(), 1'b0, C_ZERO);
    busF = 1'b0;
    push(1'b0, 1'b0, fetchS(1'b0), 1'b0, C_ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; rst = e.rstIn;
      @(negedge clk);
      checks++;
      if (obsS() !== e.s) begin failures++; $display("FAIL mem_timeout strobes t=%0t got=%h exp=%h", $time, obsS(), e.s); end
      @(posedge clk); #1;
    end
  endtask

  // Undefined opcode, then undefined R-type function
  task automatic test_invalid();
    exp_t e;
    logic [5:0] opcs [2];
    logic [5:0] funcs [2];
    opcs = '{6'h3F, 6'h00};
    funcs = '{6'h20, 6'h3F};
    for (int k = 0; k < 2; k++) begin
      opc = opcs[k]; func = funcs[k];
      push(1'b0, 1'b1, fetchS(1'b0), 1'b0, C_ZERO);
      push(1'b1, 1'b0, fetchS(1'b1), 1'b0, C_ZERO);
      push(1'b0, 1'b0, decodeS(1'b0), 1'b0, C_ZERO);
      invF = 1'b1;
      push(1'b1, 1'b0, trapS(), 1'b0, C_ZERO);
      push(1'b0, 1'b1, trapS(), 1'b0, C_ZERO);
      invF = 1'b0;
      push(1'b0, 1'b0, fetchS(1'b0), 1'b1, C_ZERO);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        mem_ready = e.rdy; rst = e.rstIn;
        @(negedge clk);
        checks++;
        if (obsS() !== e.s) begin failures++; $display("FAIL invalid%0d strobes t=%0t got=%h exp=%h", k, $time, obsS(), e.s); end
        if (e.chk) begin
          checks++;
          if (obsC() !== e.c) begin failures++; $display("FAIL invalid%0d ctrl t=%0t got=%h exp=%h", k, $time, obsC(), e.c); end
        end
        @(posedge clk); #1;
      end
    end
    func = 6'h20;
  endtask

  // Same BGEZ into both instances: the REGIMM-less one must trap
  task automatic test_regimm_disabled();
    exp_t e;
    opc = 6'h01; rt_field = 5'd1;
    push(1'b0, 1'b1, fetchS(1'b0), 1'b0, C_ZERO);
    push2(1'b1, 1'b0, fetchS(1'b1), 3'd0, 1'b0);
    push2(1'b0, 1'b0, decodeS(1'b0), 3'd1, 1'b0);
    push2(1'b0, 1'b0, execS(3'd5), 3'd7, 1'b1);
    push2(1'b0, 1'b1, fetchS(1'b0), 3'd7, 1'b1);
    push2(1'b0, 1'b0, fetchS(1'b0), 3'd0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; rst = e.rstIn;
      @(negedge clk);
      checks++;
      if (obsS() !== e.s) begin failures++; $display("FAIL regimm strobes t=%0t got=%h exp=%h", $time, obsS(), e.s); end
      if (e.chk2) begin
        checks++;
        if ({stateB, invOpcodeB} !== {e.st2, e.inv2}) begin
          failures++;
          $display("FAIL regimm_off state/inv t=%0t got=%h/%b exp=%h/%b", $time, stateB, invOpcodeB, e.st2, e.inv2);
        end
      end
      @(posedge clk); #1;
    end
    rt_field = 5'd0;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_load_word();
    test_store_byte();
    test_branch();
    test_jump();
    test_fetch_timeout();
    test_mem_timeout();
    test_invalid();
    test_regimm_disabled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
